// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one 8-bit Avalon-MM PIO between two requesters.
// Optional readback check enabled by defining PIO_ARB_READBACK_EN.
module pio_write_arbiter #(
   parameter int GAP_CYCLES = 2,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic [1:0]        pio_address,
   output logic              pio_chipselect,
   output logic              pio_write_n,
   output logic [31:0]       pio_writedata,
   input  logic [31:0]       pio_readdata,
   output logic [DATA_W-1:0] shadow,
   output logic              last_grant,
   output logic              busy,
   output logic              readback_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      VERIFY = 2'd2,
      GAP    = 2'd3
   } state_t;

   localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [3:0] GAP_LOAD = 4'(GAP_LOAD_I);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        gap_q, gap_d;
   logic              cs_q, cs_d;
   logic              wn_q, wn_d;
   logic              lg_q, lg_d;
   logic              err_q, err_d;

   logic              sel;
   logic              grant;
   logic [DATA_W-1:0] sel_data;

   // Tie goes to the requester not served last time
   assign sel      = (req0_valid & req1_valid) ? ~lg_q : req1_valid;
   assign grant    = (state_q == IDLE) & (req0_valid | req1_valid) & ~reset;
   assign sel_data = sel ? req1_data : req0_data;

   assign req0_ready = grant & ~sel;
   assign req1_ready = grant & sel;

`ifdef PIO_ARB_READBACK_EN
   logic unused_rd;
   assign unused_rd = ^pio_readdata[31:DATA_W];
`else
   logic unused_rd;
   assign unused_rd = ^pio_readdata;
`endif

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      shadow_d = shadow_q;
      wdata_d  = wdata_q;
      gap_d    = gap_q;
      lg_d     = lg_q;
      err_d    = err_q;
      cs_d     = 1'b0;
      wn_d     = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               data_d  = sel_data;
               lg_d    = sel;
               cs_d    = 1'b1;
               wn_d    = 1'b0;
               wdata_d = {{(32-DATA_W){1'b0}}, sel_data};
               state_d = WRITE;
            end
         end
         WRITE: begin
            shadow_d = data_q;
`ifdef PIO_ARB_READBACK_EN
            cs_d    = 1'b1;
            state_d = VERIFY;
`else
            if (GAP_CYCLES > 0) begin
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end else begin
               state_d = IDLE;
            end
`endif
         end
         VERIFY: begin
`ifdef PIO_ARB_READBACK_EN
            if (pio_readdata[DATA_W-1:0] != data_q) begin
               err_d = 1'b1;
            end
            if (GAP_CYCLES > 0) begin
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         GAP: begin
            if (gap_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         data_q   <= '0;
         shadow_q <= '0;
         wdata_q  <= '0;
         gap_q    <= '0;
         cs_q     <= 1'b0;
         wn_q     <= 1'b1;
         lg_q     <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
         wdata_q  <= wdata_d;
         gap_q    <= gap_d;
         cs_q     <= cs_d;
         wn_q     <= wn_d;
         lg_q     <= lg_d;
         err_q    <= err_d;
      end
   end

   assign pio_address    = 2'b00;
   assign pio_chipselect = cs_q;
   assign pio_write_n    = wn_q;
   assign pio_writedata  = wdata_q;
   assign shadow         = shadow_q;
   assign last_grant     = lg_q;
   assign busy           = (state_q != IDLE);
   assign readback_err   = err_q;

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: directed requests, monitor checks
// every PIO write against the expected byte queue.
module tb_pio_write_arbiter;

   localparam int GAP = 2;
`ifdef PIO_ARB_READBACK_EN
   localparam int VF = 1;
`else
   localparam int VF = 0;
`endif
   localparam int PERIOD = 2 + GAP + VF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0;
   logic [7:0]  req0_data = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [7:0]  req1_data = '0;
   logic        req1_ready;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   logic [31:0] pio_readdata;
   logic [7:0]  shadow;
   logic        last_grant;
   logic        busy;
   logic        readback_err;

   logic        corrupt = 1'b0;
   logic [7:0]  slave_q = '0;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic [7:0]  exp_q[$];
   int          wr_cyc[$];
   logic [7:0]  mon_e;

   pio_write_arbiter #(.GAP_CYCLES(GAP), .DATA_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .req0_valid(req0_valid),
      .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_data(req1_data),
      .req1_ready(req1_ready),
      .pio_address(pio_address),
      .pio_chipselect(pio_chipselect),
      .pio_write_n(pio_write_n),
      .pio_writedata(pio_writedata),
      .pio_readdata(pio_readdata),
      .shadow(shadow),
      .last_grant(last_grant),
      .busy(busy),
      .readback_err(readback_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // PIO slave: register 0 with combinational readback, optionally corrupted
   always @(posedge clk) begin
      if (pio_chipselect && !pio_write_n) slave_q <= pio_writedata[7:0];
   end
   assign pio_readdata = corrupt ? 32'h0 : {24'h0, slave_q};

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (req0_ready || req1_ready)
            check("ready_excl", {31'b0, req0_ready & req1_ready}, 32'h0);
         if (pio_chipselect && !pio_write_n) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("sb_write_expected", 32'h0, 32'h1);
            end else begin
               mon_e = exp_q.pop_front();
               check("pio_writedata", pio_writedata, {24'h0, mon_e});
               check("pio_address", {30'h0, pio_address}, 32'h0);
            end
         end
      end
   end

   task automatic wait_rdy(input int ch);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((ch == 0) ? req0_ready : req1_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("ready_seen", {31'b0, ok}, 32'h1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 60);
      check("idle_reached", {31'b0, busy}, 32'h0);
   endtask

   task automatic check_spacing(input string name, input int nwr);
      check({name, "_count"}, wr_cyc.size(), nwr);
      for (int i = 1; i < wr_cyc.size(); i++)
         check({name, "_spacing"}, wr_cyc[i] - wr_cyc[i-1], PERIOD);
   endtask

   initial begin
      int n;
      int grants;

      // Reset values
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_cs", {31'b0, pio_chipselect}, 32'h0);
      check("rst_wn", {31'b0, pio_write_n}, 32'h1);
      check("rst_addr", {30'b0, pio_address}, 32'h0);
      check("rst_wdata", pio_writedata, 32'h0);
      check("rst_shadow", {24'b0, shadow}, 32'h0);
      check("rst_last_grant", {31'b0, last_grant}, 32'h1);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_err", {31'b0, readback_err}, 32'h0);
      check("rst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);

      // Single write from requester 0
      @(posedge clk);
      #1;
      req0_valid = 1'b1;
      req0_data  = 8'h5A;
      exp_q.push_back(8'h5A);
      wait_rdy(0);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      check("w1_cs", {31'b0, pio_chipselect}, 32'h1);
      check("w1_wn", {31'b0, pio_write_n}, 32'h0);
      check("w1_busy", {31'b0, busy}, 32'h1);
      n = 1;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("w1_busy_cycles", n, PERIOD);
      check("w1_shadow", {24'b0, shadow}, 32'h5A);
      check("w1_last_grant", {31'b0, last_grant}, 32'h0);
      check("w1_bus_idle", {31'b0, pio_chipselect}, 32'h0);
      check("w1_wdata_hold", pio_writedata, 32'h5A);

      // Contention from fresh reset: alternate starting with requester 0
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      wr_cyc.delete();
      req0_valid = 1'b1;
      req0_data  = 8'h11;
      req1_valid = 1'b1;
      req1_data  = 8'h22;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      grants = 0;
      for (int i = 0; i < 100 && grants < 4; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) grants++;
      end
      check("rr_grants", grants, 4);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
      check_spacing("rr", 4);
      check("rr_last_grant", {31'b0, last_grant}, 32'h1);
      check("rr_sb_drained", exp_q.size(), 0);

      // Back-to-back bytes from requester 1
      wr_cyc.delete();
      @(posedge clk);
      #1;
      req1_valid = 1'b1;
      req1_data  = 8'h01;
      exp_q.push_back(8'h01);
      for (int k = 1; k <= 4; k++) begin
         wait_rdy(1);
         @(posedge clk);
         #1;
         if (k < 4) begin
            req1_data = 8'(k + 1);
            exp_q.push_back(8'(k + 1));
         end else begin
            req1_valid = 1'b0;
         end
      end
      wait_idle();
      check_spacing("b2b", 4);
      check("b2b_shadow", {24'b0, shadow}, 32'h04);

      // Reset in the middle of a transaction, pending requester 1
      @(posedge clk);
      #1;
      req0_valid = 1'b1;
      req0_data  = 8'hA5;
      exp_q.push_back(8'hA5);
      wait_rdy(0);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      check("mid_write_cs", {31'b0, pio_chipselect}, 32'h1);
      @(posedge clk);
      #1;
      reset      = 1'b1;
      req1_valid = 1'b1;
      req1_data  = 8'h3C;
      @(negedge clk);
      check("rst_wins_ready", {31'b0, req1_ready}, 32'h0);
      check("mid_busy", {31'b0, busy}, 32'h1);
      check("mid_shadow", {24'b0, shadow}, 32'hA5);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_shadow", {24'b0, shadow}, 32'h0);
      check("abort_cs", {31'b0, pio_chipselect}, 32'h0);
      check("abort_wn", {31'b0, pio_write_n}, 32'h1);
      check("abort_wdata", pio_writedata, 32'h0);
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_lg", {31'b0, last_grant}, 32'h1);
      check("post_rst_grant", {31'b0, req1_ready}, 32'h1);
      exp_q.push_back(8'h3C);
      @(posedge clk);
      #1 req1_valid = 1'b0;
      wait_idle();
      check("post_rst_shadow", {24'b0, shadow}, 32'h3C);

      // Readback mismatch, then a matching write
      @(posedge clk);
      #1;
      corrupt    = 1'b1;
      req0_valid = 1'b1;
      req0_data  = 8'hFF;
      exp_q.push_back(8'hFF);
      wait_rdy(0);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      wait_idle();
      check("rb_err_set", {31'b0, readback_err}, VF);
      @(posedge clk);
      #1;
      corrupt    = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 8'h33;
      exp_q.push_back(8'h33);
      wait_rdy(0);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      wait_idle();
      check("rb_err_sticky", {31'b0, readback_err}, VF);
      check("final_shadow", {24'b0, shadow}, 32'h33);
      check("final_sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pio_write_arbiter.md
Name: pio_write_arbiter

Overview:
- Shares one 8-bit Avalon-MM PIO output slave between two hardware requesters, e.g. the NES core status engine and the debug overlay.
- Each requester uses a valid/ready byte handshake.
- The block arbitrates round-robin and issues single-cycle Avalon writes to PIO register 0.
- It enforces a programmable idle gap between writes so downstream observers (LEDs, scope, latch logic) see every value.

Parameters:
- GAP_CYCLES, 2: idle cycles inserted after each PIO write before the next grant. Legal range 0..15.
- DATA_W, 8: requester data width. Fixed at 8 to match the PIO.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a byte to write
- req0_data  input  8  requester 0 byte
- req0_ready  output  1  requester 0 byte accepted this cycle
- req1_valid  input  1  requester 1 has a byte to write
- req1_data  input  8  requester 1 byte
- req1_ready  output  1  requester 1 byte accepted this cycle
- pio_address  output  2  Avalon address to PIO; always 0
- pio_chipselect  output  1  Avalon chipselect
- pio_write_n  output  1  Avalon write strobe, active low
- pio_writedata  output  32  Avalon write data, {24'b0, byte}
- pio_readdata  input  32  PIO readdata; combinational in the slave
- shadow  output  8  last byte written to the PIO
- last_grant  output  1  index of the most recently granted requester
- busy  output  1  high whenever state != IDLE
- readback_err  output  1  sticky mismatch flag (optional feature only)

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values:
  - state=IDLE, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0
  - shadow=0, last_grant=1 (so requester 0 wins the first tie), busy=0
  - readyN=0, readback_err=0, gap counter=0
- Reset asserted mid-operation aborts any write or gap immediately: next cycle all outputs are at reset values and the state is IDLE. A byte latched but not yet written is discarded; its requester already saw ready, so it is lost by design.
- States: IDLE, WRITE, [VERIFY], GAP.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, for the granted requester only.
  - Grant rule:
    - only req0_valid → grant 0
    - only req1_valid → grant 1
    - both → grant = ~last_grant
    - neither → stay IDLE, no ready
  - On grant (valid&ready): latch the byte into the data register, set last_grant, go to WRITE next cycle.
- WRITE (exactly 1 cycle):
  - pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={24'b0,data}.
  - shadow updates to data at the end of this cycle.
  - Next state: VERIFY if the feature is enabled; else GAP if GAP_CYCLES>0; else IDLE.
- GAP:
  - Bus idle (chipselect=0, write_n=1).
  - Counter loads GAP_CYCLES-1 on entry and decrements; exit to IDLE when it reaches 0. Total GAP dwell = GAP_CYCLES cycles.
- Bus outputs are registered. pio_writedata holds its last value while chipselect=0.
- Throughput: one write per (2+GAP_CYCLES) cycles, or (3+GAP_CYCLES) with the feature enabled.
  - Grant → write latency is 1 cycle.
  - Worst-case wait for a continuously asserted valid is one other requester's full transaction.
- Requester valid may drop without acceptance; no penalty and no state change. Data is only sampled in the grant cycle.
- Simultaneous reset and valid: reset wins, no ready is asserted.

Optional Feature:
- Macro: PIO_ARB_READBACK_EN.
- Defined: after WRITE, the FSM enters VERIFY for 1 cycle.
  - Bus: pio_chipselect=1, pio_write_n=1, pio_address=0.
  - pio_readdata[7:0] is compared with the written byte. On mismatch, readback_err sets and stays set until reset.
  - VERIFY then goes to GAP, or to IDLE if GAP_CYCLES=0.
- Undefined: no VERIFY state, readback_err tied 0, pio_readdata unused.

Test Plan:
- Reset, then req0_valid=1 with data 0x5A: req0_ready high in cycle 0; cycle 1 chipselect=1, write_n=0, writedata=0x0000005A; shadow=0x5A after; busy low again after 2+GAP_CYCLES cycles.
- Both valid continuously (req0=0x11, req1=0x22) for 4 grants: PIO write sequence 0x11,0x22,0x11,0x22; ready never asserted for both requesters in the same cycle.
- GAP_CYCLES=0 with back-to-back req1 bytes 0x01..0x04: one write every 2 cycles, no idle bus cycles beyond IDLE.
- Reset asserted during GAP after a write of 0xA5: next cycle shadow=0, bus idle, state IDLE; a pending req1 is granted the cycle after reset deasserts.
- With PIO_ARB_READBACK_EN, slave model returns 0x00 for write 0xFF: readback_err=1 and stays set through later matching writes; with the macro undefined, readback_err stays 0 and each write takes 2+GAP_CYCLES cycles.
